// File: rtl/arbiter_pkg.sv
// Shared constants, state encoding and a lowest-set-bit helper for request_arbiter.
package arbiter_pkg;

    localparam int unsigned N     = 16;
    localparam int unsigned IDX_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_e;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [N-1:0] v);
        logic found;
        lowest_idx = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (v[i] && !found) begin
                lowest_idx = IDX_W'(i);
                found      = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/request_arbiter_rr_select.sv
// Round-robin pick: lowest pending bit at or above ptr, else lowest pending bit overall.
module rr_select
    import arbiter_pkg::*;
(
    input  logic [N-1:0]     pending,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] sel_idx,
    output logic             sel_any
);

    logic [N-1:0] masked;

    always_comb begin
        masked = '0;
        for (int unsigned i = 0; i < N; i++) begin
            masked[i] = pending[i] & (i >= 32'(ptr));
        end
    end

    always_comb begin
        sel_any = |pending;
        if (|masked) begin
            sel_idx = lowest_idx(masked);
        end else begin
            sel_idx = lowest_idx(pending);
        end
    end

endmodule

// File: rtl/request_arbiter.sv
// Registered round-robin arbiter: sticky request capture, one-hot + index grant over valid/ready.
module request_arbiter
    import arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req_in,
    input  logic             clr_all,
    input  logic             grant_ready,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N-1:0]     grant_onehot,
    output logic [N-1:0]     pending,
    output logic             busy
);

    localparam logic [N-1:0] ONE = N'(1);

    arb_state_e       state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [N-1:0]     grant_onehot_q, grant_onehot_d;

    logic [IDX_W-1:0] sel_idx;
    logic             sel_any;
    logic             accept;
    logic [N-1:0]     accept_mask;

    rr_select u_rr_select (
        .pending (pending_q),
        .ptr     (ptr_q),
        .sel_idx (sel_idx),
        .sel_any (sel_any)
    );

    assign accept      = grant_valid_q & grant_ready;
    assign accept_mask = accept ? grant_onehot_q : '0;

    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        ptr_d          = ptr_q;
        grant_valid_d  = grant_valid_q;
        grant_idx_d    = grant_idx_q;
        grant_onehot_d = grant_onehot_q;

        if (clr_all) begin
            state_d        = IDLE;
            pending_d      = '0;
            grant_valid_d  = 1'b0;
            grant_onehot_d = '0;
        end else begin
            // OR-ing req_in last lets a same-cycle re-request survive its own accept
            pending_d = (pending_q & ~accept_mask) | req_in;
            unique case (state_q)
                IDLE: begin
                    if (sel_any) begin
                        state_d        = OFFER;
                        grant_valid_d  = 1'b1;
                        grant_idx_d    = sel_idx;
                        grant_onehot_d = ONE << sel_idx;
                    end
                end
                OFFER: begin
                    if (accept) begin
                        state_d        = IDLE;
                        grant_valid_d  = 1'b0;
                        grant_onehot_d = '0;
                        ptr_d          = grant_idx_q + IDX_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            pending_q      <= '0;
            ptr_q          <= '0;
            grant_valid_q  <= 1'b0;
            grant_idx_q    <= '0;
            grant_onehot_q <= '0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            ptr_q          <= ptr_d;
            grant_valid_q  <= grant_valid_d;
            grant_idx_q    <= grant_idx_d;
            grant_onehot_q <= grant_onehot_d;
        end
    end

    assign grant_valid  = grant_valid_q;
    assign grant_idx    = grant_idx_q;
    assign grant_onehot = grant_onehot_q;
    assign pending      = pending_q;
    assign busy         = (pending_q != '0) | grant_valid_q;

endmodule

// File: tb/tb_request_arbiter.sv
// Directed self-checking bench for request_arbiter.
module tb_request_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] req_in;
    logic        clr_all;
    logic        grant_ready;
    logic        grant_valid;
    logic [3:0]  grant_idx;
    logic [15:0] grant_onehot;
    logic [15:0] pending;
    logic        busy;

    int checks = 0;
    int passed = 0;

    request_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req_in       (req_in),
        .clr_all      (clr_all),
        .grant_ready  (grant_ready),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
        .pending      (pending),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_in = '0; clr_all = 1'b0; grant_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        checks++; if (grant_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", grant_valid); else passed++;
        checks++; if (grant_idx !== 4'd0) $display("FAIL reset_idx: got %0d want 0", grant_idx); else passed++;
        checks++; if (grant_onehot !== 16'h0000) $display("FAIL reset_onehot: got %h want 0000", grant_onehot); else passed++;
        checks++; if (pending !== 16'h0000) $display("FAIL reset_pending: got %h want 0000", pending); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_single();
        req_in = 16'h0001; grant_ready = 1'b1;
        tick();
        req_in = '0;
        checks++; if (pending !== 16'h0001) $display("FAIL single_pending: got %h want 0001", pending); else passed++;
        checks++; if (grant_valid !== 1'b0) $display("FAIL single_latency: got valid %b want 0", grant_valid); else passed++;
        tick();
        checks++; if (grant_valid !== 1'b1 || grant_idx !== 4'd0 || grant_onehot !== 16'h0001)
            $display("FAIL single_grant: got v=%b idx=%0d oh=%h want v=1 idx=0 oh=0001", grant_valid, grant_idx, grant_onehot); else passed++;
        tick();
        checks++; if (grant_valid !== 1'b0 || pending !== 16'h0000 || busy !== 1'b0)
            $display("FAIL single_accept: got v=%b pend=%h busy=%b want 0 0000 0", grant_valid, pending, busy); else passed++;
        checks++; if (dut.ptr_q !== 4'd1) $display("FAIL single_ptr: got %0d want 1", dut.ptr_q); else passed++;
    endtask

    task automatic test_wrap();
        req_in = 16'h8001; grant_ready = 1'b1;
        tick();
        req_in = '0;
        tick();
        checks++; if (grant_valid !== 1'b1 || grant_idx !== 4'd15 || grant_onehot !== 16'h8000)
            $display("FAIL wrap_first: got v=%b idx=%0d oh=%h want v=1 idx=15 oh=8000", grant_valid, grant_idx, grant_onehot); else passed++;
        tick();
        checks++; if (grant_valid !== 1'b0 || pending !== 16'h0001 || dut.ptr_q !== 4'd0)
            $display("FAIL wrap_gap: got v=%b pend=%h ptr=%0d want 0 0001 0", grant_valid, pending, dut.ptr_q); else passed++;
        tick();
        checks++; if (grant_valid !== 1'b1 || grant_idx !== 4'd0 || grant_onehot !== 16'h0001)
            $display("FAIL wrap_second: got v=%b idx=%0d oh=%h want v=1 idx=0 oh=0001", grant_valid, grant_idx, grant_onehot); else passed++;
        tick();
        checks++; if (grant_valid !== 1'b0 || pending !== 16'h0000 || dut.ptr_q !== 4'd1)
            $display("FAIL wrap_end: got v=%b pend=%h ptr=%0d want 0 0000 1", grant_valid, pending, dut.ptr_q); else passed++;
    endtask

    task automatic test_backpressure();
        req_in = 16'h0030; grant_ready = 1'b0;
        tick();
        req_in = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (grant_valid !== 1'b1 || grant_idx !== 4'd4 || grant_onehot !== 16'h0010 || pending !== 16'h0030)
                $display("FAIL bp_hold[%0d]: got v=%b idx=%0d oh=%h pend=%h want 1 4 0010 0030",
                         i, grant_valid, grant_idx, grant_onehot, pending); else passed++;
            tick();
        end
        grant_ready = 1'b1;
        tick();
        checks++; if (grant_valid !== 1'b0 || pending !== 16'h0020 || dut.ptr_q !== 4'd5)
            $display("FAIL bp_accept: got v=%b pend=%h ptr=%0d want 0 0020 5", grant_valid, pending, dut.ptr_q); else passed++;
        tick();
        checks++; if (grant_valid !== 1'b1 || grant_idx !== 4'd5 || grant_onehot !== 16'h0020)
            $display("FAIL bp_next: got v=%b idx=%0d oh=%h want 1 5 0020", grant_valid, grant_idx, grant_onehot); else passed++;
        tick();
        checks++; if (grant_valid !== 1'b0 || pending !== 16'h0000 || dut.ptr_q !== 4'd6)
            $display("FAIL bp_end: got v=%b pend=%h ptr=%0d want 0 0000 6", grant_valid, pending, dut.ptr_q); else passed++;
    endtask

    task automatic test_set_and_accept();
        req_in = 16'h0008; grant_ready = 1'b0;
        tick();
        req_in = '0;
        tick();
        checks++; if (grant_valid !== 1'b1 || grant_idx !== 4'd3)
            $display("FAIL sa_offer: got v=%b idx=%0d want 1 3", grant_valid, grant_idx); else passed++;
        grant_ready = 1'b1; req_in = 16'h0008;
        tick();
        req_in = '0;
        checks++; if (grant_valid !== 1'b0 || pending !== 16'h0008 || dut.ptr_q !== 4'd4)
            $display("FAIL sa_retain: got v=%b pend=%h ptr=%0d want 0 0008 4", grant_valid, pending, dut.ptr_q); else passed++;
        tick();
        checks++; if (grant_valid !== 1'b1 || grant_idx !== 4'd3 || grant_onehot !== 16'h0008)
            $display("FAIL sa_regrant: got v=%b idx=%0d oh=%h want 1 3 0008", grant_valid, grant_idx, grant_onehot); else passed++;
        tick();
        checks++; if (grant_valid !== 1'b0 || pending !== 16'h0000)
            $display("FAIL sa_end: got v=%b pend=%h want 0 0000", grant_valid, pending); else passed++;
    endtask

    task automatic test_flush();
        req_in = 16'hFFFF; grant_ready = 1'b0;
        tick();
        req_in = '0;
        tick();
        checks++; if (grant_valid !== 1'b1 || grant_idx !== 4'd4 || pending !== 16'hFFFF)
            $display("FAIL flush_offer: got v=%b idx=%0d pend=%h want 1 4 FFFF", grant_valid, grant_idx, pending); else passed++;
        clr_all = 1'b1; req_in = 16'h0001;
        tick();
        clr_all = 1'b0; req_in = '0;
        checks++; if (grant_valid !== 1'b0 || pending !== 16'h0000 || busy !== 1'b0 || grant_onehot !== 16'h0000)
            $display("FAIL flush_clear: got v=%b pend=%h busy=%b oh=%h want 0 0000 0 0000",
                     grant_valid, pending, busy, grant_onehot); else passed++;
        checks++; if (dut.ptr_q !== 4'd4) $display("FAIL flush_ptr: got %0d want 4", dut.ptr_q); else passed++;
        tick();
        checks++; if (grant_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL flush_idle: got v=%b busy=%b want 0 0", grant_valid, busy); else passed++;
    endtask

    task automatic test_reset_mid_offer();
        req_in = 16'h0004; grant_ready = 1'b0;
        tick();
        req_in = 16'h0002;
        tick();
        req_in = '0;
        checks++; if (grant_valid !== 1'b1 || grant_idx !== 4'd2 || pending !== 16'h0006)
            $display("FAIL rst_offer: got v=%b idx=%0d pend=%h want 1 2 0006", grant_valid, grant_idx, pending); else passed++;
        grant_ready = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; grant_ready = 1'b0;
        checks++; if (grant_valid !== 1'b0 || grant_idx !== 4'd0 || grant_onehot !== 16'h0000 || pending !== 16'h0000 || busy !== 1'b0)
            $display("FAIL rst_outputs: got v=%b idx=%0d oh=%h pend=%h busy=%b want all 0",
                     grant_valid, grant_idx, grant_onehot, pending, busy); else passed++;
        checks++; if (dut.ptr_q !== 4'd0) $display("FAIL rst_ptr: got %0d want 0", dut.ptr_q); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_set_and_accept();
        test_flush();
        test_reset_mid_offer();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
